// File: rtl/gpu_pkg.sv
// Shared types for the SIMT core: sequencer states, LSU lane states,
// fetcher handshake value and the reconvergence stack entry.
package gpu_pkg;

    localparam int SIMT_THREADS = 4;
    localparam int SIMT_PC_W    = 8;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_t;

    localparam logic [2:0] FETCHED = 3'b010;

    // One deferred path: where it resumes and which lanes take it.
    typedef struct packed {
        logic [SIMT_PC_W-1:0]    pc;
        logic [SIMT_THREADS-1:0] mask;
    } simt_entry_t;

    // A lane still has a memory transaction outstanding.
    function automatic logic lsu_busy(input logic [1:0] s);
        return (lsu_state_t'(s) == LSU_REQ) || (lsu_state_t'(s) == LSU_WAIT);
    endfunction

endpackage

// File: rtl/simt_stack.sv
// Reconvergence LIFO. A push into a full stack is dropped; the caller
// flags it. Reset clears only the pointer, entry storage is don't-care.
module simt_stack
    import gpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  simt_entry_t push_entry,
    output simt_entry_t top,
    output logic        empty,
    output logic        full
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    simt_entry_t      mem_q [DEPTH];
    simt_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    assign empty = (ptr_q == '0);
    assign full  = (ptr_q == PTR_W'(DEPTH));
    assign top   = mem_q[IDX_W'(ptr_q - PTR_W'(1))];

    // Next pointer and storage; push takes priority if both are requested.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (push) begin
            if (!full) begin
                mem_d[IDX_W'(ptr_q)] = push_entry;
                ptr_d                = ptr_q + PTR_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
        end
    end

    // Stack pointer register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Entry storage, no reset needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/simt_core_scheduler.sv
// Per-core sequencer: steps the core through the instruction phases,
// owns PC, active-thread mask and the SIMT reconvergence stack.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; loads launch mask and PC 0
//   FETCH   | waiting for the fetcher to report FETCHED
//   DECODE  | decoder settles its outputs (one cycle)
//   REQUEST | LSUs issue requests (one cycle)
//   WAIT    | held while any active lane has a memory op outstanding
//   EXECUTE | ALUs / PC units compute (one cycle)
//   UPDATE  | apply PC / mask / stack rule; RET ends the block
//   DONE    | block finished; only reset leaves this state
module simt_core_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS = SIMT_THREADS,
    parameter int PC_W    = SIMT_PC_W,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [$clog2(THREADS):0] thread_count,
    input  logic [2:0]              fetcher_state,
    input  logic [2*THREADS-1:0]    lsu_state,
    input  logic                    decoded_ssy,
    input  logic                    decoded_sync,
    input  logic                    decoded_ret,
    input  logic [7:0]              decoded_immediate,
    input  logic [PC_W*THREADS-1:0] next_pc,
    output logic [2:0]              core_state,
    output logic [PC_W-1:0]         current_pc,
    output logic [THREADS-1:0]      active_mask,
    output logic                    done,
    output logic                    stack_overflow
);

    localparam int TC_W = $clog2(THREADS) + 1;

    core_state_t        state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [THREADS-1:0] mask_q, mask_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               push, pop;
    simt_entry_t        push_entry;
    simt_entry_t        stk_top;
    logic               stk_empty, stk_full;

    logic [THREADS-1:0] launch_mask;
    logic               lsu_stall;
    logic               lead_found, rest_found;
    logic [PC_W-1:0]    lead_pc, rest_pc;
    logic [THREADS-1:0] group_mask, rest_mask;

    simt_stack #(.DEPTH(DEPTH)) u_stack (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .top        (stk_top),
        .empty      (stk_empty),
        .full       (stk_full)
    );

    // Launch mask: lanes below thread_count, never beyond the physical lanes.
    always_comb begin
        launch_mask = '0;
        for (int i = 0; i < THREADS; i++) begin
            if (TC_W'(i) < thread_count) launch_mask[i] = 1'b1;
        end
    end

    // Memory stall only counts lanes that are part of this instruction.
    always_comb begin
        lsu_stall = 1'b0;
        for (int i = 0; i < THREADS; i++) begin
            if (mask_q[i] && lsu_busy(lsu_state[2*i +: 2])) lsu_stall = 1'b1;
        end
    end

    // Branch grouping: the lowest active lane leads; lanes agreeing with it
    // keep running, the lowest disagreeing lane names the deferred path.
    always_comb begin
        lead_found = 1'b0;
        lead_pc    = '0;
        for (int i = 0; i < THREADS; i++) begin
            if (mask_q[i] && !lead_found) begin
                lead_found = 1'b1;
                lead_pc    = next_pc[i*PC_W +: PC_W];
            end
        end
        group_mask = '0;
        for (int i = 0; i < THREADS; i++) begin
            group_mask[i] = mask_q[i] && (next_pc[i*PC_W +: PC_W] == lead_pc);
        end
        rest_mask  = mask_q & ~group_mask;
        rest_found = 1'b0;
        rest_pc    = '0;
        for (int i = 0; i < THREADS; i++) begin
            if (rest_mask[i] && !rest_found) begin
                rest_found = 1'b1;
                rest_pc    = next_pc[i*PC_W +: PC_W];
            end
        end
    end

    // Next-state, PC, mask and stack control.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mask_d     = mask_q;
        ovf_d      = ovf_q;
        push       = 1'b0;
        pop        = 1'b0;
        push_entry = '0;
        case (state_q)
            CORE_IDLE: begin
                if (start) begin
                    state_d = CORE_FETCH;
                    pc_d    = '0;
                    mask_d  = launch_mask;
                end
            end
            CORE_FETCH:   if (fetcher_state == FETCHED) state_d = CORE_DECODE;
            CORE_DECODE:  state_d = CORE_REQUEST;
            CORE_REQUEST: state_d = CORE_WAIT;
            CORE_WAIT:    if (!lsu_stall) state_d = CORE_EXECUTE;
            CORE_EXECUTE: state_d = CORE_UPDATE;
            CORE_UPDATE: begin
                state_d = decoded_ret ? CORE_DONE : CORE_FETCH;
                if (decoded_ssy) begin
                    push            = 1'b1;
                    push_entry.pc   = decoded_immediate[PC_W-1:0];
                    push_entry.mask = mask_q;
                    pc_d            = pc_q + PC_W'(1);
                end else if (decoded_sync) begin
                    if (!stk_empty) begin
                        pop    = 1'b1;
                        pc_d   = stk_top.pc;
                        mask_d = stk_top.mask;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end else begin
                    pc_d = lead_pc;
                    if (group_mask != mask_q) begin
                        push            = 1'b1;
                        push_entry.pc   = rest_pc;
                        push_entry.mask = rest_mask;
                        mask_d          = group_mask;
                    end
                end
                // A dropped push loses a path; keep the flag until reset.
                if (push && stk_full) ovf_d = 1'b1;
            end
            CORE_DONE: state_d = CORE_DONE;
        endcase
        done_d = (state_d == CORE_DONE);
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CORE_IDLE;
            pc_q    <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign core_state     = state_q;
    assign current_pc     = pc_q;
    assign active_mask    = mask_q;
    assign done           = done_q;
    assign stack_overflow = ovf_q;

endmodule

// File: tb/tb_simt_core_scheduler.sv
// Bench for simt_core_scheduler: directed scenarios plus randomized
// instruction streams checked against a queue-based SIMT model.
module tb_simt_core_scheduler;
    import gpu_pkg::*;

    localparam int THREADS = 4;
    localparam int PC_W    = 8;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  thread_count;
    logic [2:0]  fetcher_state;
    logic [7:0]  lsu_state;
    logic        decoded_ssy, decoded_sync, decoded_ret;
    logic [7:0]  decoded_immediate;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic [3:0]  active_mask;
    logic        done;
    logic        stack_overflow;

    always #5 clk = ~clk;

    simt_core_scheduler #(.THREADS(THREADS), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .fetcher_state     (fetcher_state),
        .lsu_state         (lsu_state),
        .decoded_ssy       (decoded_ssy),
        .decoded_sync      (decoded_sync),
        .decoded_ret       (decoded_ret),
        .decoded_immediate (decoded_immediate),
        .next_pc           (next_pc),
        .core_state        (core_state),
        .current_pc        (current_pc),
        .active_mask       (active_mask),
        .done              (done),
        .stack_overflow    (stack_overflow)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain integers and a queue as the stack.
    typedef struct {
        int pc;
        int mask;
    } mentry_t;

    mentry_t mdl_stack[$];
    int      mdl_pc   = 0;
    int      mdl_mask = 0;
    bit      mdl_ovf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void mdl_reset();
        mdl_pc   = 0;
        mdl_mask = 0;
        mdl_ovf  = 1'b0;
        mdl_stack.delete();
    endfunction

    function automatic void mdl_push(input int pc, input int mask);
        if (mdl_stack.size() >= DEPTH) mdl_ovf = 1'b1;
        else mdl_stack.push_back('{pc, mask});
    endfunction

    function automatic void mdl_update(input bit u_ssy, input bit u_sync, input int u_imm,
                                       input logic [31:0] u_npc);
        int      lane_pc[THREADS];
        int      lead;
        int      grp;
        int      rest;
        int      rest_lane;
        mentry_t e;
        for (int i = 0; i < THREADS; i++) lane_pc[i] = int'(u_npc[i*8 +: 8]);
        if (u_ssy) begin
            mdl_push(u_imm % 256, mdl_mask);
            mdl_pc = (mdl_pc + 1) % 256;
        end else if (u_sync) begin
            if (mdl_stack.size() > 0) begin
                e        = mdl_stack.pop_back();
                mdl_pc   = e.pc;
                mdl_mask = e.mask;
            end else begin
                mdl_pc = (mdl_pc + 1) % 256;
            end
        end else begin
            lead = -1;
            for (int i = 0; i < THREADS; i++)
                if (lead < 0 && ((mdl_mask >> i) & 1) == 1) lead = i;
            grp = 0;
            for (int i = 0; i < THREADS; i++)
                if (((mdl_mask >> i) & 1) == 1 && lane_pc[i] == lane_pc[lead]) grp |= (1 << i);
            rest      = mdl_mask & ~grp;
            rest_lane = -1;
            for (int i = 0; i < THREADS; i++)
                if (rest_lane < 0 && ((rest >> i) & 1) == 1) rest_lane = i;
            if (rest != 0) begin
                mdl_push(lane_pc[rest_lane], rest);
                mdl_mask = grp;
            end
            mdl_pc = lane_pc[lead];
        end
    endfunction

    // Active lanes see idle/done or one forced busy lane; inactive lanes always look busy.
    task automatic drive_lsu(input bit busy, input int lane);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < THREADS; i++) begin
            if (((mdl_mask >> i) & 1) == 1) begin
                if (busy && i == lane) v[2*i +: 2] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
                else v[2*i +: 2] = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
            end else begin
                v[2*i +: 2] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            end
        end
        lsu_state = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mdl_reset();
    endtask

    task automatic launch(input int tc);
        check("idle_before_start", core_state, CORE_IDLE);
        thread_count = 3'(tc);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mdl_pc   = 0;
        mdl_mask = (1 << tc) - 1;
        check("launch_state", core_state, CORE_FETCH);
        check("launch_mask", active_mask, mdl_mask);
        check("launch_pc", current_pc, mdl_pc);
    endtask

    task automatic run_instr(input bit i_ssy, input bit i_sync, input bit i_ret,
                             input logic [7:0] i_imm, input logic [31:0] i_npc,
                             input int fdelay, input int stall);
        int cycles;
        int act[$];
        int lane;
        int fv;
        check("fetch_state", core_state, CORE_FETCH);
        decoded_ssy       = i_ssy;
        decoded_sync      = i_sync;
        decoded_ret       = i_ret;
        decoded_immediate = i_imm;
        next_pc           = i_npc;
        for (int d = 0; d < fdelay; d++) begin
            fv = $urandom_range(0, 6);
            if (fv >= 2) fv++;
            fetcher_state = 3'(fv);
            @(negedge clk);
            check("fetch_hold", core_state, CORE_FETCH);
        end
        fetcher_state = FETCHED;
        cycles = 0;
        @(negedge clk); cycles++;
        fetcher_state = 3'b000;
        check("decode_state", core_state, CORE_DECODE);
        @(negedge clk); cycles++;
        check("request_state", core_state, CORE_REQUEST);
        for (int i = 0; i < THREADS; i++) if (((mdl_mask >> i) & 1) == 1) act.push_back(i);
        lane = act[$urandom_range(0, act.size() - 1)];
        for (int j = 0; j <= stall; j++) begin
            @(negedge clk); cycles++;
            check("wait_state", core_state, CORE_WAIT);
            drive_lsu(j < stall, lane);
        end
        @(negedge clk); cycles++;
        check("execute_state", core_state, CORE_EXECUTE);
        @(negedge clk); cycles++;
        check("update_state", core_state, CORE_UPDATE);
        mdl_update(i_ssy, i_sync, int'(i_imm), i_npc);
        @(negedge clk); cycles++;
        check("post_state", core_state, i_ret ? CORE_DONE : CORE_FETCH);
        check("post_pc", current_pc, mdl_pc);
        check("post_mask", active_mask, mdl_mask);
        check("post_ovf", stack_overflow, mdl_ovf);
        check("post_done", done, i_ret);
        check("latency", cycles, stall + 6);
    endtask

    function automatic logic [31:0] uni_npc(input int v);
        return {4{8'(v)}};
    endfunction

    task automatic random_burst(input int n);
        int          r;
        logic [31:0] npc;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            for (int i = 0; i < THREADS; i++)
                npc[i*8 +: 8] = ($urandom_range(0, 2) != 0) ? 8'((mdl_pc + 1) % 256)
                                                             : 8'($urandom_range(40, 41));
            run_instr(r < 2, (r == 2) || (r == 3), 1'b0, 8'($urandom),
                      npc, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        thread_count      = 3'd0;
        fetcher_state     = 3'b000;
        lsu_state         = 8'h00;
        decoded_ssy       = 1'b0;
        decoded_sync      = 1'b0;
        decoded_ret       = 1'b0;
        decoded_immediate = 8'h00;
        next_pc           = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_state", core_state, CORE_IDLE);
        check("rst_pc", current_pc, 0);
        check("rst_mask", active_mask, 0);
        check("rst_done", done, 0);
        check("rst_ovf", stack_overflow, 0);
        reset = 1'b0;
        mdl_reset();
        @(negedge clk);
        check("idle_hold", core_state, CORE_IDLE);

        // Launch with 3 threads, fetch held, uniform step, then a long memory wait.
        launch(3);
        check("launch3_mask", active_mask, 4'b0111);
        run_instr(1'b0, 1'b0, 1'b0, 8'h00, uni_npc(1), 4, 0);
        check("uniform_pc", current_pc, 1);
        run_instr(1'b0, 1'b0, 1'b0, 8'h00, uni_npc(2), 0, 5);
        random_burst(15);

        // Divergence / reconvergence with all four lanes.
        do_reset();
        launch(4);
        run_instr(1'b0, 1'b0, 1'b0, 8'h00, uni_npc(1), 0, 0);
        run_instr(1'b0, 1'b0, 1'b0, 8'h00, uni_npc(2), 1, 0);
        check("ssy_pc_before", current_pc, 2);
        run_instr(1'b1, 1'b0, 1'b0, 8'd9, uni_npc(77), 0, 1);
        check("ssy_pc_after", current_pc, 3);
        run_instr(1'b0, 1'b0, 1'b0, 8'h00, {8'd5, 8'd5, 8'd3, 8'd3}, 0, 0);
        check("div_mask", active_mask, 4'b0011);
        check("div_pc", current_pc, 3);
        run_instr(1'b0, 1'b1, 1'b0, 8'h00, uni_npc(0), 0, 0);
        check("sync1_mask", active_mask, 4'b1100);
        check("sync1_pc", current_pc, 5);
        run_instr(1'b0, 1'b1, 1'b0, 8'h00, uni_npc(0), 0, 0);
        check("sync2_mask", active_mask, 4'b1111);
        check("sync2_pc", current_pc, 9);

        // Overflow: DEPTH+1 SSYs, then unwind and one SYNC on an empty stack.
        for (int k = 0; k <= DEPTH; k++) begin
            run_instr(1'b1, 1'b0, 1'b0, 8'(20 + k), uni_npc(0), 0, 0);
            check("ovf_progress", stack_overflow, (k == DEPTH) ? 1 : 0);
        end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            run_instr(1'b0, 1'b1, 1'b0, 8'h00, uni_npc(0), 0, 0);
            check("ovf_pop_pc", current_pc, 20 + k);
        end
        run_instr(1'b0, 1'b1, 1'b0, 8'h00, uni_npc(0), 0, 0);
        check("sync_empty_pc", current_pc, 21);
        check("ovf_sticky", stack_overflow, 1);

        // RET: DONE holds and start is ignored.
        run_instr(1'b0, 1'b0, 1'b1, 8'h00, uni_npc(22), 0, 0);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            @(negedge clk);
            check("done_hold_state", core_state, CORE_DONE);
            check("done_hold_flag", done, 1);
        end
        start = 1'b0;

        // Random stream with random thread count, then reset in the middle of WAIT.
        do_reset();
        launch($urandom_range(1, 4));
        random_burst(20);
        check("pre_abort_state", core_state, CORE_FETCH);
        fetcher_state = FETCHED;
        @(negedge clk);
        fetcher_state = 3'b000;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_wait", core_state, CORE_WAIT);
        drive_lsu(1'b1, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", core_state, CORE_IDLE);
        check("abort_pc", current_pc, 0);
        check("abort_mask", active_mask, 0);
        check("abort_done", done, 0);
        check("abort_ovf", stack_overflow, 0);
        reset = 1'b0;
        mdl_reset();
        @(negedge clk);
        check("abort_idle_hold", core_state, CORE_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
